// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
//   Write-side pointer and flag generator for an asynchronous FIFO. Counts
//   accepted writes in binary, drives the RAM write address/strobe, and
//   publishes a registered Gray write pointer toward the read-domain
//   synchronizer. Full, level, sticky overflow and (optionally) almost-full
//   are derived from the already-synchronized read Gray pointer.
//
//   Optional feature macro: FIFO_WPTR_ALMOST_FULL_EN
//     defined   : walmost_full is a registered (level >= AFULL_THRESH) flag
//     undefined : walmost_full is tied low, AFULL_THRESH has no effect
//
// Ports
//   wclk           in   write-domain clock (posedge)
//   rst            in   synchronous reset, active-high
//   winc           in   write request from producer
//   rptr_gray_sync in   read Gray pointer, already synchronized into wclk
//   wen            out  RAM write strobe, winc & ~wfull (combinational)
//   waddr          out  RAM write address, low ADDR_W bits of binary pointer
//   wptr_gray      out  registered Gray write pointer for the CDC
//   wfull          out  registered full flag
//   wlevel         out  registered occupancy seen from write side, 0..DEPTH
//   wovf           out  sticky overflow, write attempted while full
//   walmost_full   out  registered almost-full flag (see macro above)
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned AFULL_THRESH = 12
) (
   input  logic              wclk,
   input  logic              rst,
   input  logic              winc,
   input  logic [ADDR_W:0]   rptr_gray_sync,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr_gray,
   output logic              wfull,
   output logic [ADDR_W:0]   wlevel,
   output logic              wovf,
   output logic              walmost_full
);

   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Elaboration-time parameter sanity check
   if (ADDR_W < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_param
      $error("fifo_wptr_full: need ADDR_W>=2 and 1<=AFULL_THRESH<=2**ADDR_W");
   end

   logic [PTR_W-1:0] wbin_q,   wbin_d;
   logic [PTR_W-1:0] wgray_q,  wgray_d;
   logic             wfull_q,  wfull_d;
   logic [PTR_W-1:0] wlevel_q, wlevel_d;
   logic             wovf_q,   wovf_d;
   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] full_gray;
   logic             accept;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      rbin = '0;
      for (int i = 0; i < int'(PTR_W); i++) begin
         rbin[i] = ^(rptr_gray_sync >> i);
      end
   end

   // Next-state pointers and flags; write and read-pointer movement in the
   // same cycle are both folded into this compute
   always_comb begin
      accept    = winc & ~wfull_q;
      wbin_d    = wbin_q + PTR_W'(accept);
      wgray_d   = wbin_d ^ (wbin_d >> 1);
      // Full when the write Gray pointer is DEPTH ahead: top two Gray bits
      // inverted relative to the read pointer, remaining bits equal
      full_gray = {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]};
      wfull_d   = (wgray_d == full_gray);
      wlevel_d  = wbin_d - rbin;
      wovf_d    = wovf_q | (winc & wfull_q);
   end

   always_ff @(posedge wclk) begin
      if (rst) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         wfull_q  <= 1'b0;
         wlevel_q <= '0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         wfull_q  <= wfull_d;
         wlevel_q <= wlevel_d;
         wovf_q   <= wovf_d;
      end
   end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
   logic walmost_full_q, walmost_full_d;

   always_comb begin
      walmost_full_d = (wlevel_d >= PTR_W'(AFULL_THRESH));
   end

   always_ff @(posedge wclk) begin
      if (rst) begin
         walmost_full_q <= 1'b0;
      end else begin
         walmost_full_q <= walmost_full_d;
      end
   end

   assign walmost_full = walmost_full_q;
`else
   assign walmost_full = 1'b0;
`endif

   assign wen       = accept;
   assign waddr     = wbin_q[ADDR_W-1:0];
   assign wptr_gray = wgray_q;
   assign wfull     = wfull_q;
   assign wlevel    = wlevel_q;
   assign wovf      = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_fifo_wptr_full
//   Bench for fifo_wptr_full at ADDR_W=2 (DEPTH=4), AFULL_THRESH=3.
//   Directed table of write/read-pointer vectors, reset while full, then a
//   randomized run against a write/read counting model.
// ---------------------------------------------------------------------------
module tb_fifo_wptr_full;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned PTR_W  = 3;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned THRESH = 3;

   logic              wclk = 1'b0;
   logic              rst;
   logic              winc;
   logic [PTR_W-1:0]  rptr_gray_sync;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [PTR_W-1:0]  wptr_gray;
   logic              wfull;
   logic [PTR_W-1:0]  wlevel;
   logic              wovf;
   logic              walmost_full;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_wptr_full #(.ADDR_W(ADDR_W), .AFULL_THRESH(THRESH)) dut (
      .wclk           (wclk),
      .rst            (rst),
      .winc           (winc),
      .rptr_gray_sync (rptr_gray_sync),
      .wen            (wen),
      .waddr          (waddr),
      .wptr_gray      (wptr_gray),
      .wfull          (wfull),
      .wlevel         (wlevel),
      .wovf           (wovf),
      .walmost_full   (walmost_full)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic             winc;
      logic [PTR_W-1:0] rgray;
      logic             exp_wen;    // before the edge
      logic [1:0]       exp_waddr;  // before the edge
      logic [PTR_W-1:0] exp_gray;   // after the edge
      logic             exp_full;
      logic [PTR_W-1:0] exp_level;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray_of(input int count);
      int b;
      b = count % 8;
      return b ^ (b >> 1);
   endfunction

   function automatic int afull_exp(input int level);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      return (level >= int'(THRESH)) ? 1 : 0;
`else
      return (level >= 0) ? 0 : 0;
`endif
   endfunction

   task automatic check_regs(input string tag, input int g, input int f, input int l, input int o);
      chk({tag, ".wptr_gray"}, int'(wptr_gray), g);
      chk({tag, ".wfull"}, int'(wfull), f);
      chk({tag, ".wlevel"}, int'(wlevel), l);
      chk({tag, ".wovf"}, int'(wovf), o);
      chk({tag, ".walmost_full"}, int'(walmost_full), afull_exp(l));
   endtask

   task automatic do_reset();
      @(negedge wclk);
      rst = 1'b1;
      winc = 1'b0;
      rptr_gray_sync = '0;
      @(posedge wclk);
      #1;
      rst = 1'b0;
   endtask

   int wr_total;
   int rd_total;
   int lvl_m;
   bit full_m;
   bit ovf_m;
   bit w;

   initial begin
      rst = 1'b1;
      winc = 1'b0;
      rptr_gray_sync = '0;

      vecs[0] = '{1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0, 3'd1, 1'b0};
      vecs[1] = '{1'b1, 3'b000, 1'b1, 2'd1, 3'b011, 1'b0, 3'd2, 1'b0};
      vecs[2] = '{1'b1, 3'b000, 1'b1, 2'd2, 3'b010, 1'b0, 3'd3, 1'b0};
      vecs[3] = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b110, 1'b1, 3'd4, 1'b0};
      vecs[4] = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1};
      vecs[5] = '{1'b0, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1};
      vecs[6] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 3'd3, 1'b1};
      vecs[7] = '{1'b1, 3'b001, 1'b1, 2'd0, 3'b111, 1'b1, 3'd4, 1'b1};

      // Reset state
      do_reset();
      chk("reset.waddr", int'(waddr), 0);
      check_regs("reset", 0, 0, 0, 0);

      // Directed fill, overflow, read free and refill
      for (int i = 0; i < 8; i++) begin
         @(negedge wclk);
         winc = vecs[i].winc;
         rptr_gray_sync = vecs[i].rgray;
         #1;
         chk($sformatf("vec%0d.wen", i), int'(wen), int'(vecs[i].exp_wen));
         chk($sformatf("vec%0d.waddr", i), int'(waddr), int'(vecs[i].exp_waddr));
         @(posedge wclk);
         #1;
         check_regs($sformatf("vec%0d", i), int'(vecs[i].exp_gray), int'(vecs[i].exp_full),
                    int'(vecs[i].exp_level), int'(vecs[i].exp_ovf));
      end

      // Reset while full with overflow latched clears everything
      do_reset();
      chk("rst_full.waddr", int'(waddr), 0);
      check_regs("rst_full", 0, 0, 0, 0);

      // Simultaneous write and read-pointer move: one in, one out -> level holds
      @(negedge wclk); winc = 1'b1; rptr_gray_sync = 3'b000;
      @(posedge wclk); #1;
      @(negedge wclk); winc = 1'b1; rptr_gray_sync = 3'b001;
      @(posedge wclk); #1;
      check_regs("simul", 3'b011, 0, 1, 0);
      do_reset();

      // Randomized run against a counting model (writes total vs reads total)
      wr_total = 0;
      rd_total = 0;
      full_m   = 1'b0;
      ovf_m    = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge wclk);
         w = ($urandom_range(0, 3) != 0);
         if (c >= 200 && c < 240) w = 1'b1;   // drive into full/overflow
         if (rd_total < wr_total && $urandom_range(0, 2) != 0) rd_total++;
         winc = w;
         rptr_gray_sync = PTR_W'(gray_of(rd_total));
         #1;
         chk("rand.wen", int'(wen), int'(w && !full_m));
         chk("rand.waddr", int'(waddr), wr_total % int'(DEPTH));
         @(posedge wclk);
         if (w && full_m) ovf_m = 1'b1;
         if (w && !full_m) wr_total++;
         lvl_m  = wr_total - rd_total;
         full_m = (lvl_m == int'(DEPTH));
         #1;
         check_regs("rand", gray_of(wr_total), int'(full_m), lvl_m, int'(ovf_m));
      end
      chk("rand.wrapped", int'(wr_total > 8), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
